// File: rtl/apb_uart_tx_pkg.sv
// apb_uart_tx shared types: register offsets, FSM states, CTRL layout.
// Also holds the frame parity helper used when a frame is latched.
package apb_uart_tx_pkg;

  localparam logic [4:0] REG_TXDATA = 5'h00;
  localparam logic [4:0] REG_CTRL   = 5'h04;
  localparam logic [4:0] REG_BAUD   = 5'h08;
  localparam logic [4:0] REG_STATUS = 5'h0C;
  localparam logic [4:0] REG_INTEN  = 5'h10;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_e;

  typedef struct packed {
    logic       cts_en;
    logic       en;
    logic       stop2;
    logic [1:0] par;
    logic [1:0] dlen;
  } ctrl_t;

  function automatic logic par_on(logic [1:0] par);
    return (par == PAR_EVEN) || (par == PAR_ODD);
  endfunction

  // Only the DLEN+5 transmitted bits contribute to parity.
  function automatic logic par_bit(logic [7:0] d,
                                   logic [1:0] dlen,
                                   logic [1:0] par);
    logic [7:0] m;
    m = ~(8'hFF << (4'(dlen) + 4'd5));
    return (^(d & m)) ^ (par == PAR_ODD);
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO with flush and level output.
// A push while full is dropped; flush overrides push and pop.
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  input  logic             flush_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [AW:0]      level_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wp_q, rp_q;
  logic [AW:0]      cnt_q;
  logic             do_push, do_pop;

  assign full_o  = cnt_q == (AW+1)'(DEPTH);
  assign empty_o = cnt_q == '0;
  assign do_push = push_i & ~full_o & ~flush_i;
  assign do_pop  = pop_i & ~empty_o & ~flush_i;
  assign data_o  = mem_q[rp_q];
  assign level_o = cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n || flush_i) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wp_q <= wp_q + 1'b1;
      if (do_pop)  rp_q <= rp_q + 1'b1;
      cnt_q <= cnt_q + (AW+1)'(do_push)
                     - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wp_q] <= data_i;
  end

endmodule

// File: rtl/apb_uart_tx.sv
// APB-programmable UART transmitter with TX FIFO,
// runtime frame format, baud divisor and CTS flow control.
import apb_uart_tx_pkg::*;

module apb_uart_tx #(
  parameter int          APB_ADDR_WIDTH = 12,
  parameter int          APB_DATA_WIDTH = 32,
  parameter int          FIFO_DEPTH     = 16,
  parameter int          DIV_WIDTH      = 16,
  parameter int unsigned DIV_RESET      = 'd867
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [APB_ADDR_WIDTH-1:0] apb_paddr,
  input  logic                      apb_psel,
  input  logic                      apb_penable,
  input  logic                      apb_pwrite,
  input  logic [APB_DATA_WIDTH-1:0] apb_pwdata,
  output logic                      apb_pready,
  output logic [APB_DATA_WIDTH-1:0] apb_prdata,
  output logic                      apb_pslverr,
  input  logic                      cts_n,
  output logic                      tx,
  output logic                      irq
);

  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  logic                 access, wr, mapped;
  logic [4:0]           addr;
  ctrl_t                ctrl_q;
  logic [DIV_WIDTH-1:0] div_q;
  logic                 ie_q;
  logic                 f_push, f_pop, f_flush;
  logic                 f_full, f_empty;
  logic [7:0]           f_data;
  logic [LW-1:0]        f_level;
  logic                 cts_s1_q, cts_s2_q;
  tx_state_e            state_q;
  logic [DIV_WIDTH-1:0] cnt_q, fdiv_q;
  logic [2:0]           bit_q;
  logic [7:0]           sh_q;
  logic [1:0]           fdlen_q, fpar_q;
  logic                 fstop2_q, fpb_q, stop2nd_q;
  logic                 tx_q, irq_q;
  logic                 start_ok, bit_end, frame_end;
  logic                 unused_bits;

  assign unused_bits = ^{apb_paddr, apb_pwdata};

  assign access = apb_psel & apb_penable;
  assign wr     = access & apb_pwrite;
  assign addr   = apb_paddr[4:0];
  assign mapped = addr inside {REG_TXDATA, REG_CTRL,
                               REG_BAUD, REG_STATUS,
                               REG_INTEN};

  assign apb_pready  = access;
  assign apb_pslverr = access & (~mapped | (apb_pwrite &
    ((addr == REG_TXDATA && f_full) ||
     addr == REG_STATUS)));

  always_comb begin
    apb_prdata = '0;
    if (access) begin
      case (addr)
        REG_CTRL:   apb_prdata[6:0] = ctrl_q;
        REG_BAUD:   apb_prdata[DIV_WIDTH-1:0] = div_q;
        REG_STATUS: begin
          apb_prdata[0]    = state_q != IDLE;
          apb_prdata[1]    = f_full;
          apb_prdata[2]    = f_empty;
          apb_prdata[15:8] = 8'(f_level);
        end
        REG_INTEN:  apb_prdata[0] = ie_q;
        default:    apb_prdata = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ctrl_q <= '0;
      div_q  <= DIV_WIDTH'(DIV_RESET);
      ie_q   <= 1'b0;
    end else if (wr) begin
      case (addr)
        REG_CTRL:  ctrl_q <= ctrl_t'(apb_pwdata[6:0]);
        REG_BAUD:  div_q  <= apb_pwdata[DIV_WIDTH-1:0];
        REG_INTEN: ie_q   <= apb_pwdata[0];
        default:   ;
      endcase
    end
  end

  assign f_push  = wr && addr == REG_TXDATA;
  assign f_flush = wr && addr == REG_CTRL && apb_pwdata[7];

  uart_sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (reset_n),
    .push_i  (f_push),
    .data_i  (apb_pwdata[7:0]),
    .pop_i   (f_pop),
    .flush_i (f_flush),
    .data_o  (f_data),
    .full_o  (f_full),
    .empty_o (f_empty),
    .level_o (f_level)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cts_s1_q <= 1'b1;
      cts_s2_q <= 1'b1;
    end else begin
      cts_s1_q <= cts_n;
      cts_s2_q <= cts_s1_q;
    end
  end

  assign start_ok  = ctrl_q.en & ~f_empty &
                     (~ctrl_q.cts_en | ~cts_s2_q);
  assign bit_end   = cnt_q == fdiv_q;
  assign frame_end = state_q == STOP && bit_end &&
                     (!fstop2_q || stop2nd_q);
  assign f_pop     = start_ok &&
                     (state_q == IDLE || frame_end);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      tx_q      <= 1'b1;
      cnt_q     <= '0;
      bit_q     <= '0;
      sh_q      <= '0;
      fdlen_q   <= '0;
      fpar_q    <= PAR_NONE;
      fstop2_q  <= 1'b0;
      fdiv_q    <= '0;
      fpb_q     <= 1'b0;
      stop2nd_q <= 1'b0;
    end else begin
      cnt_q <= bit_end ? '0 : cnt_q + 1'b1;
      if (f_pop) begin
        // Frame format is frozen here for the whole frame.
        state_q   <= START;
        tx_q      <= 1'b0;
        cnt_q     <= '0;
        sh_q      <= f_data;
        fdlen_q   <= ctrl_q.dlen;
        fpar_q    <= ctrl_q.par;
        fstop2_q  <= ctrl_q.stop2;
        fdiv_q    <= div_q;
        fpb_q     <= par_bit(f_data, ctrl_q.dlen,
                             ctrl_q.par);
        stop2nd_q <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            tx_q  <= 1'b1;
            cnt_q <= '0;
          end
          START: if (bit_end) begin
            state_q <= DATA;
            bit_q   <= '0;
            tx_q    <= sh_q[0];
          end
          DATA: if (bit_end) begin
            if (bit_q == 3'(fdlen_q) + 3'd4) begin
              if (par_on(fpar_q)) begin
                state_q <= PARITY;
                tx_q    <= fpb_q;
              end else begin
                state_q <= STOP;
                tx_q    <= 1'b1;
              end
            end else begin
              bit_q <= bit_q + 1'b1;
              sh_q  <= sh_q >> 1;
              tx_q  <= sh_q[1];
            end
          end
          PARITY: if (bit_end) begin
            state_q <= STOP;
            tx_q    <= 1'b1;
          end
          STOP: if (bit_end) begin
            if (frame_end) state_q <= IDLE;
            else           stop2nd_q <= 1'b1;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) irq_q <= 1'b0;
    else irq_q <= ie_q & f_empty & (state_q == IDLE);
  end

  assign tx  = tx_q;
  assign irq = irq_q;

endmodule

// File: tb/tb_apb_uart_tx.sv
// Bench for apb_uart_tx: queued expected frames checked
// by a serial monitor, plus register and flow-control checks.
module tb_apb_uart_tx;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [11:0] paddr;
  logic        psel, penable, pwrite;
  logic [31:0] pwdata, prdata;
  logic        pready, pslverr;
  logic        cts_n, tx, irq;

  always #5 clk = ~clk;

  apb_uart_tx dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .apb_paddr   (paddr),
    .apb_psel    (psel),
    .apb_penable (penable),
    .apb_pwrite  (pwrite),
    .apb_pwdata  (pwdata),
    .apb_pready  (pready),
    .apb_prdata  (prdata),
    .apb_pslverr (pslverr),
    .cts_n       (cts_n),
    .tx          (tx),
    .irq         (irq)
  );

  typedef struct {
    logic [7:0] d;
    logic [1:0] dlen;
    logic [1:0] par;
    logic       stop2;
    int         div;
  } exp_t;

  exp_t       exp_q[$];
  int         n_tests = 0;
  int         n_fail  = 0;
  logic [1:0] c_dlen, c_par;
  logic       c_stop2;
  int         c_div;
  bit         mon_busy = 0;
  bit         b2b_exp  = 0;
  bit         irq_chk  = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h exp 0x%0h",
               tag, got, exp);
    end
  endtask

  task automatic apb_wr(input logic [11:0] a,
                        input logic [31:0] d,
                        output logic err);
    @(negedge clk);
    paddr = a; pwrite = 1'b1; pwdata = d;
    psel = 1'b1; penable = 1'b0;
    @(negedge clk);
    penable = 1'b1;
    #1;
    check("pready_wr", pready, 1);
    err = pslverr;
    @(posedge clk);
    #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic apb_rd(input logic [11:0] a,
                        output logic [31:0] d,
                        output logic err);
    @(negedge clk);
    paddr = a; pwrite = 1'b0;
    psel = 1'b1; penable = 1'b0;
    @(negedge clk);
    penable = 1'b1;
    #1;
    d = prdata;
    err = pslverr;
    @(posedge clk);
    #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic set_cfg(input logic [7:0] ctrl,
                         input int div);
    logic e;
    apb_wr(12'h008, div, e);
    apb_wr(12'h004, {24'd0, ctrl}, e);
    c_dlen  = ctrl[1:0];
    c_par   = ctrl[3:2];
    c_stop2 = ctrl[4];
    c_div   = div;
  endtask

  task automatic send(input logic [7:0] d);
    logic e;
    exp_q.push_back('{d: d, dlen: c_dlen, par: c_par,
                      stop2: c_stop2, div: c_div});
    apb_wr(12'h000, {24'd0, d}, e);
    check("push_err", e, 0);
  endtask

  task automatic wait_done(input string tag,
                           input int maxc);
    bit done;
    done = 0;
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !mon_busy) begin
        done = 1;
        break;
      end
    end
    check(tag, done, 1);
  endtask

  function automatic void build(input exp_t e,
                                output logic [11:0] b,
                                output int nb);
    logic p;
    p  = 1'b0;
    b  = '0;
    nb = 1;
    for (int i = 0; i < int'(e.dlen) + 5; i++) begin
      b[nb] = e.d[i];
      p ^= e.d[i];
      nb++;
    end
    if (e.par == 2'b01) begin b[nb] = p; nb++; end
    else if (e.par == 2'b10) begin b[nb] = ~p; nb++; end
    b[nb] = 1'b1; nb++;
    if (e.stop2) begin b[nb] = 1'b1; nb++; end
  endfunction

  initial begin : monitor
    logic [11:0] eb, gb;
    int          nb, bi;
    bit          stable, pend, irq_bad;
    exp_t        e;
    logic        s;
    pend = 0;
    forever begin
      if (!pend) begin @(posedge clk); #1; end
      pend = 0;
      if (tx === 1'b0) begin
        mon_busy = 1;
        if (exp_q.size() == 0) begin
          check("unexpected_frame", 1, 0);
          for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            if (tx === 1'b1) break;
          end
        end else begin
          e = exp_q.pop_front();
          build(e, eb, nb);
          gb = '0; stable = 1; irq_bad = 0;
          for (int c = 0; c < nb * (e.div + 1); c++) begin
            if (c > 0) begin @(posedge clk); #1; end
            s  = tx;
            bi = c / (e.div + 1);
            if (c % (e.div + 1) == 0) gb[bi] = s;
            else if (s !== gb[bi]) stable = 0;
            if (irq !== 1'b0) irq_bad = 1;
          end
          check("frame_bits", gb, eb);
          check("bit_timing", stable, 1);
          if (irq_chk) begin
            check("irq_busy", irq_bad, 0);
            @(posedge clk); #1;
            check("irq_stop_end", irq, 0);
            @(posedge clk); #1;
            check("irq_set", irq, 1);
            irq_chk = 0;
          end
          if (b2b_exp && exp_q.size() != 0) begin
            @(posedge clk); #1;
            check("b2b_start", tx, 0);
            pend = 1;
          end
        end
        mon_busy = 0;
      end
    end
  end

  initial begin : main
    logic [31:0] d;
    logic        e;
    bit          found;
    logic [7:0]  fmts [2];
    reset_n = 1'b0; psel = 0; penable = 0; pwrite = 0;
    paddr = '0; pwdata = '0; cts_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx", tx, 1);
    check("rst_irq", irq, 0);
    check("rst_pready", pready, 0);
    check("rst_prdata", prdata, 0);
    check("rst_pslverr", pslverr, 0);
    @(negedge clk);
    reset_n = 1'b1;
    apb_rd(12'h004, d, e); check("rst_ctrl", d, 0);
    apb_rd(12'h008, d, e); check("rst_baud", d, 867);
    apb_rd(12'h00C, d, e); check("rst_status", d, 32'h4);
    apb_rd(12'h010, d, e); check("rst_inten", d, 0);

    // 8N1
    set_cfg(8'h23, 3);
    apb_rd(12'h004, d, e); check("ctrl_rd", d, 32'h23);
    send(8'hAB);
    apb_rd(12'h00C, d, e); check("busy_mid", d[0], 1);
    wait_done("t1_done", 200);
    apb_rd(12'h00C, d, e); check("t1_idle", d, 32'h4);

    // 8E1 then 8O1, 5N2
    set_cfg(8'h27, 3); send(8'hAB);
    wait_done("t2e_done", 200);
    set_cfg(8'h2B, 3); send(8'hAB);
    wait_done("t2o_done", 200);
    set_cfg(8'h30, 3); send(8'hFF);
    wait_done("t3_done", 200);

    // FIFO full / flush with EN=0
    set_cfg(8'h03, 3);
    for (int i = 0; i < 16; i++) begin
      apb_wr(12'h000, i, e);
      check("fill_err", e, 0);
    end
    apb_wr(12'h000, 32'h99, e); check("full_err", e, 1);
    apb_rd(12'h00C, d, e); check("st_full", d, 32'h1002);
    apb_wr(12'h00C, 32'h0, e); check("st_wr_err", e, 1);
    apb_wr(12'h004, 32'h80, e); check("flush_err", e, 0);
    apb_rd(12'h00C, d, e); check("st_flushed", d, 32'h4);
    apb_rd(12'h004, d, e); check("flush_rd0", d, 0);

    // CTS flow control
    cts_n = 1'b1;
    repeat (3) @(negedge clk);
    set_cfg(8'h63, 3);
    send(8'h5A); send(8'hC3);
    repeat (20) @(negedge clk);
    check("cts_hold_tx", tx, 1);
    check("cts_hold_q", exp_q.size(), 2);
    apb_rd(12'h00C, d, e); check("cts_status", d, 32'h200);
    @(negedge clk);
    cts_n = 1'b0;
    found = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (tx === 1'b0) begin found = 1; break; end
    end
    check("cts_start", found, 1);
    repeat (10) @(negedge clk);
    cts_n = 1'b1;
    found = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (exp_q.size() == 1 && !mon_busy) begin
        found = 1; break;
      end
    end
    check("cts_frame1", found, 1);
    repeat (20) @(negedge clk);
    check("cts_held_tx", tx, 1);
    check("cts_held_q", exp_q.size(), 1);
    cts_n = 1'b0;
    wait_done("cts_frame2", 200);

    // TX-empty interrupt and unmapped access
    set_cfg(8'h23, 3);
    apb_wr(12'h010, 32'h1, e);
    repeat (2) @(negedge clk);
    check("irq_idle", irq, 1);
    apb_rd(12'h010, d, e); check("inten_rd", d, 1);
    irq_chk = 1;
    send(8'h3C);
    wait_done("t6_done", 200);
    apb_rd(12'h018, d, e);
    check("unmap_rd", d, 0);
    check("unmap_rd_err", e, 1);
    apb_wr(12'h014, 32'h5, e); check("unmap_wr_err", e, 1);

    // Back-to-back random frames in two formats
    fmts[0] = 8'h06;
    fmts[1] = 8'h19;
    for (int f = 0; f < 2; f++) begin
      set_cfg(fmts[f], 1);
      for (int i = 0; i < 4; i++) send(8'($urandom));
      b2b_exp = 1;
      apb_wr(12'h004, {24'd0, fmts[f] | 8'h20}, e);
      wait_done("b2b_done", 400);
      b2b_exp = 0;
    end

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
